// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with ripple carry/borrow, validated parallel load,
// synchronous clear and selectable wrap or saturate behaviour at the range ends.
module bcd_updown_counter #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   load_val_i,
   input  logic                  ena_i,
   input  logic                  up_i,
   output logic [4*DIGITS-1:0]   cnt_o,
   output logic                  carry_o,
   output logic                  tc_o,
   output logic                  load_err_o
);

   logic [4*DIGITS-1:0] cnt_reg;
   logic [4*DIGITS-1:0] cnt_step;
   logic                carry_reg;
   logic                load_err_reg;
   logic [DIGITS-1:0]   is9;
   logic [DIGITS-1:0]   is0;
   logic [DIGITS-1:0]   nibble_ok;
   logic                all9;
   logic                all0;
   logic                load_ok;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign is9[gi]       = (cnt_reg[4*gi +: 4] == 4'd9);
         assign is0[gi]       = (cnt_reg[4*gi +: 4] == 4'd0);
         assign nibble_ok[gi] = (load_val_i[4*gi +: 4] <= 4'd9);
      end
   endgenerate

   assign load_ok = &nibble_ok;

   // Ripple chain: a digit steps only while every lower digit is at its end value.
   // After the loop all9/all0 cover the whole count and double as terminal count.
   always_comb begin
      cnt_step = cnt_reg;
      all9     = 1'b1;
      all0     = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (up_i) begin
            if (all9) begin
               cnt_step[4*k +: 4] = is9[k] ? 4'd0 : cnt_reg[4*k +: 4] + 4'd1;
            end
         end else begin
            if (all0) begin
               cnt_step[4*k +: 4] = is0[k] ? 4'd9 : cnt_reg[4*k +: 4] - 4'd1;
            end
         end
         all9 = all9 & is9[k];
         all0 = all0 & is0[k];
      end
   end

   assign tc_o = up_i ? all9 : all0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_reg      <= '0;
         carry_reg    <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         carry_reg    <= 1'b0;
         load_err_reg <= 1'b0;
         if (clr_i) begin
            cnt_reg <= '0;
         end else if (load_i) begin
            if (load_ok) begin
               cnt_reg <= load_val_i;
            end else begin
               load_err_reg <= 1'b1;
            end
         end else if (ena_i) begin
            // The stepped value already wraps naturally; saturation just suppresses it.
            if (tc_o) begin
               carry_reg <= 1'b1;
               if (WRAP) begin
                  cnt_reg <= cnt_step;
               end
            end else begin
               cnt_reg <= cnt_step;
            end
         end
      end
   end

   assign cnt_o      = cnt_reg;
   assign carry_o    = carry_reg;
   assign load_err_o = load_err_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating instance share stimulus and
// are compared against an integer-arithmetic reference model plus a table of vectors.
module tb_bcd_updown_counter;
   localparam int D    = 4;
   localparam int MAXV = 9999;

   logic        clk = 1'b0;
   logic        rst, clr, load, ena, up;
   logic [15:0] load_val;
   logic [15:0] cnt_w, cnt_s;
   logic        carry_w, carry_s, tc_w, tc_s, err_w, err_s;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(D), .WRAP(1'b1)) u_wrap (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
      .ena_i(ena), .up_i(up), .cnt_o(cnt_w), .carry_o(carry_w), .tc_o(tc_w),
      .load_err_o(err_w));

   bcd_updown_counter #(.DIGITS(D), .WRAP(1'b0)) u_sat (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
      .ena_i(ena), .up_i(up), .cnt_o(cnt_s), .carry_o(carry_s), .tc_o(tc_s),
      .load_err_o(err_s));

   int n_cmp = 0;
   int n_bad = 0;
   int mv_w, mv_s;
   bit mc_w, mc_s, me;

   typedef struct {
      bit          clr;
      bit          load;
      logic [15:0] lv;
      bit          ena;
      bit          up;
      logic [15:0] cnt;
      bit          carry;
      bit          err;
      bit          tc;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [15:0] to_bcd(int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(logic [15:0] b);
      for (int k = 0; k < D; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int from_bcd(logic [15:0] b);
      int r;
      r = 0;
      for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
      return r;
   endfunction

   function automatic int step_val(int v, bit upd, bit wrap, output bit c);
      c = 1'b0;
      if (upd) begin
         if (v == MAXV) begin c = 1'b1; return wrap ? 0 : v; end
         return v + 1;
      end
      if (v == 0) begin c = 1'b1; return wrap ? MAXV : v; end
      return v - 1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      mc_w = 1'b0; mc_s = 1'b0; me = 1'b0;
      if (clr) begin
         mv_w = 0; mv_s = 0;
      end else if (load) begin
         if (bcd_ok(load_val)) begin
            mv_w = from_bcd(load_val); mv_s = mv_w;
         end else begin
            me = 1'b1;
         end
      end else if (ena) begin
         mv_w = step_val(mv_w, up, 1'b1, mc_w);
         mv_s = step_val(mv_s, up, 1'b0, mc_s);
      end
   endtask

   task automatic check_all();
      check("w_cnt", cnt_w, to_bcd(mv_w));
      check("w_carry", carry_w, mc_w);
      check("w_err", err_w, me);
      check("w_tc", tc_w, up ? (mv_w == MAXV) : (mv_w == 0));
      check("s_cnt", cnt_s, to_bcd(mv_s));
      check("s_carry", carry_s, mc_s);
      check("s_err", err_s, me);
      check("s_tc", tc_s, up ? (mv_s == MAXV) : (mv_s == 0));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic set_in(bit c, bit l, logic [15:0] lv, bit e, bit u);
      clr = c; load = l; load_val = lv; ena = e; up = u;
   endtask

   task automatic add_vec(bit c, bit l, logic [15:0] lv, bit e, bit u,
                          logic [15:0] cn, bit ca, bit er, bit t);
      vec_t v;
      v.clr = c; v.load = l; v.lv = lv; v.ena = e; v.up = u;
      v.cnt = cn; v.carry = ca; v.err = er; v.tc = t;
      tbl.push_back(v);
   endtask

   // Reset asserted between edges must clear both instances without a clock edge.
   task automatic mid_cycle_reset(string tag);
      #1 rst = 1'b1;
      #1;
      mv_w = 0; mv_s = 0; mc_w = 1'b0; mc_s = 1'b0; me = 1'b0;
      check({tag, "_rst_cnt_w"}, cnt_w, 16'h0000);
      check({tag, "_rst_carry_w"}, carry_w, 1'b0);
      check({tag, "_rst_cnt_s"}, cnt_s, 16'h0000);
      check({tag, "_rst_carry_s"}, carry_s, 1'b0);
      #1 rst = 1'b0;
   endtask

   initial begin
      int carries;
      logic [15:0] lv;

      add_vec(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0);
      add_vec(0, 0, 16'h0000, 1, 0, 16'h0999, 0, 0, 0);
      add_vec(0, 0, 16'h0000, 1, 0, 16'h0998, 0, 0, 0);
      add_vec(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
      add_vec(0, 0, 16'h0000, 1, 0, 16'h9999, 1, 0, 0);
      add_vec(0, 1, 16'h0042, 0, 1, 16'h0042, 0, 0, 0);
      add_vec(0, 1, 16'h12A4, 1, 1, 16'h0042, 0, 1, 0);
      add_vec(0, 1, 16'h1234, 0, 1, 16'h1234, 0, 0, 0);
      add_vec(1, 1, 16'h5555, 1, 1, 16'h0000, 0, 0, 0);
      add_vec(0, 1, 16'h5555, 1, 1, 16'h5555, 0, 0, 0);
      add_vec(0, 1, 16'h9999, 0, 1, 16'h9999, 0, 0, 1);
      add_vec(0, 0, 16'h0000, 0, 0, 16'h9999, 0, 0, 0);
      add_vec(0, 0, 16'h0000, 1, 0, 16'h9998, 0, 0, 0);
      add_vec(0, 0, 16'h0000, 0, 1, 16'h9998, 0, 0, 0);
      add_vec(0, 0, 16'h0000, 1, 1, 16'h9999, 0, 0, 1);
      add_vec(0, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 0);
      add_vec(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);

      rst = 1'b1;
      set_in(0, 0, 16'h0000, 0, 1);
      mv_w = 0; mv_s = 0; mc_w = 1'b0; mc_s = 1'b0; me = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // Full up-count through the whole range and back to zero.
      carries = 0;
      set_in(0, 0, 16'h0000, 1, 1);
      for (int i = 0; i < MAXV + 1; i++) begin
         cycle();
         if (carry_w) begin
            carries++;
            check("t1_carry_at_zero", cnt_w, 16'h0000);
         end
      end
      check("t1_carry_count", carries, 1);
      check("t1_final_cnt", cnt_w, 16'h0000);

      foreach (tbl[i]) begin
         set_in(tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].ena, tbl[i].up);
         cycle();
         $display("vec %0d: cnt=%h carry=%b err=%b tc=%b", i, cnt_w, carry_w, err_w, tc_w);
         check("tbl_cnt", cnt_w, tbl[i].cnt);
         check("tbl_carry", carry_w, tbl[i].carry);
         check("tbl_err", err_w, tbl[i].err);
         check("tbl_tc", tc_w, tbl[i].tc);
      end

      // Saturating instance: repeated underflow holds at zero and pulses every cycle.
      set_in(0, 1, 16'h0000, 0, 0);
      cycle();
      set_in(0, 0, 16'h0000, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("sat_hold_cnt", cnt_s, 16'h0000);
         check("sat_hold_carry", carry_s, 1'b1);
      end

      // Async reset while carry is high, then while counting mid-range.
      set_in(0, 1, 16'h9999, 0, 1);
      cycle();
      set_in(0, 0, 16'h0000, 1, 1);
      cycle();
      check("pre_rst_carry_w", carry_w, 1'b1);
      mid_cycle_reset("a");
      cycle();
      check("post_rst_cnt_a", cnt_w, 16'h0001);
      set_in(0, 1, 16'h0398, 0, 1);
      cycle();
      set_in(0, 0, 16'h0000, 1, 1);
      cycle();
      mid_cycle_reset("b");
      cycle();
      check("post_rst_cnt_b", cnt_w, 16'h0001);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       lv = 16'($urandom);
            1:       lv = ($urandom_range(0, 1) != 0) ? 16'h9999 : 16'h0000;
            default: lv = to_bcd(int'($urandom_range(0, MAXV)));
         endcase
         set_in($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, lv,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter, the successor of the single-digit BCD counter in the keyboard/display path. It chains `DIGITS` decade stages with ripple carry/borrow between digits. Features: synchronous clear, validated parallel load, selectable wrap or saturate at the range ends, and overflow/underflow and terminal-count flags. Typical uses are key-press counting, scan timing and 7-segment display values.

## Interface
- `DIGITS`, default 4: number of BCD digits, legal range 1..8. Count range is 0 .. 10^DIGITS−1.
- `WRAP`, default 1: end-of-range behaviour.
  - 1 = wrap (99..9 → 00..0 up; 00..0 → 99..9 down).
  - 0 = saturate (hold at the range end).
- `clk_i`  in  1: single clock. All state updates on the rising edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `clr_i`  in  1: synchronous clear to 0.
- `load_i`  in  1: synchronous parallel load request.
- `load_val_i`  in  4*DIGITS: load value. Nibble k is decimal digit k; nibble 0 is the least significant.
- `ena_i`  in  1: count enable, one step per enabled cycle.
- `up_i`  in  1: direction. 1 = increment, 0 = decrement.
- `cnt_o`  out  4*DIGITS: registered BCD count, same nibble order as `load_val_i`.
- `carry_o`  out  1: registered one-cycle pulse on a range-end event (overflow when counting up, underflow when counting down).
- `tc_o`  out  1: combinational terminal count.
  - With `up_i`=1: high when `cnt_o` is all 9s.
  - With `up_i`=0: high when `cnt_o` is all 0s.
- `load_err_o`  out  1: registered one-cycle pulse when a load is rejected.

## Operation
- Reset (`rst_i`=1, at any time, independent of the clock): `cnt_o`=0, `carry_o`=0, `load_err_o`=0. Any in-progress operation is abandoned. The first edge after `rst_i` falls is evaluated normally.
- Per-edge priority: `clr_i` > `load_i` > `ena_i`. A lower-priority request in the same cycle is ignored. It is not queued.
- Clear: `cnt_o`←0. `carry_o` and `load_err_o` are 0 next cycle.
- Load: the load is valid only if every nibble of `load_val_i` is ≤ 9.
  - Valid: `cnt_o`←`load_val_i`.
  - Invalid: `cnt_o` is unchanged and `load_err_o` pulses for one cycle.
  - No partial loads.
  - `ena_i` in the same cycle is ignored either way.
- Count up, per digit:
  - Digit 0 always steps.
  - Digit k steps only when all lower digits are 9.
  - A stepping digit at 9 becomes 0; otherwise it becomes digit+1.
- Count down, per digit:
  - Digit k steps only when all lower digits are 0.
  - A stepping digit at 0 becomes 9; otherwise it becomes digit−1.
- Range-end event: an enabled step taken while `tc_o`=1 for the current direction. On that event `carry_o` pulses regardless of `WRAP`.
  - `WRAP`=1: the count wraps (all 9s → 0 up; 0 → all 9s down).
  - `WRAP`=0: `cnt_o` holds.
- Direction may change on any cycle. `up_i` is sampled on the same edge as `ena_i`.
- `cnt_o` digits are always ≤ 9. No illegal nibble is ever reachable from reset, clear, load or count.
- `ena_i`=0 with no clear or load: all state holds and both pulse outputs are 0.

## Timing
- Latency is 1 cycle for `cnt_o`: the value changes on the edge where the request is sampled.
- `carry_o` and `load_err_o` are asserted in the cycle immediately after the triggering edge, aligned with the new `cnt_o`. Each is high for exactly one cycle per event.
- Back-to-back range-end events (e.g. down-counting from 0 with `WRAP`=0 and `ena_i` held high) produce `carry_o` high on every such cycle.
- `tc_o` is combinational from `cnt_o` and `up_i` only, with no path from `ena_i`. It can change within a cycle when `up_i` toggles.
- Full-width carry chain is combinational within one cycle. The design must meet timing at `DIGITS`=8.

## Test plan
1. Reset, then `DIGITS`=4, `WRAP`=1, `up_i`=1, `ena_i` held for 10000 cycles.
   - `cnt_o` steps 0000→0001…→0009→0010…→9999→0000.
   - `carry_o` pulses exactly once, with `cnt_o`=0000.
   - `tc_o`=1 only at 9999.
2. Load and down-count.
   - Load `load_val_i`=0x1000, then down 2 steps → 0999, then 0998.
   - Load 0x0000 and step down once → 9999 with `carry_o` pulse.
   - Repeat with `WRAP`=0 → `cnt_o` stays 0000, `carry_o` still pulses.
3. Invalid load.
   - With `cnt_o`=0x0042, load 0x12A4 → `cnt_o` stays 0x0042, `load_err_o` pulses once.
   - Next, load 0x1234 → `cnt_o`=0x1234, `load_err_o`=0.
4. Priority.
   - Same cycle `clr_i`=1, `load_i`=1 (0x5555), `ena_i`=1 → `cnt_o`=0000.
   - Then `load_i`=1 with `ena_i`=1, `up_i`=1 → `cnt_o`=0x5555, not 0x5556.
5. Asynchronous reset mid-count.
   - At `cnt_o`=0x0398, up, `ena_i`=1: assert `rst_i` between edges → `cnt_o`=0, `carry_o`=0 immediately, without waiting for an edge.
   - Release `rst_i` → next enabled edge gives 0001.
6. Direction toggle at boundary.
   - At 9999 with `up_i`=0: `tc_o`=0; one step → 9998, no `carry_o`.
   - Set `up_i`=1: `tc_o` reads 0 at 9998; step → 9999, `tc_o`=1.
